// File: rtl/fc_classifier_seq.sv
`default_nettype none
// ============================================================================
// Module   : fc_classifier_seq
// Brief    : Sequential FC classifier; N_OUT parallel MACs over 50 pooled
//            activations, then a serial arg-max over the class scores.
// Revision : 1.0
// ============================================================================
module fc_classifier_seq #(
  parameter int bitwidth = 8,
  parameter int N_OUT    = 10,
  parameter int ACC_W    = 24
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [1:0][4:0][4:0][bitwidth-1:0] featuremap_maxpooled,
  input  logic signed [N_OUT-1:0][49:0][bitwidth-1:0] weights,
  input  logic signed [N_OUT-1:0][bitwidth-1:0]     bias,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [N_OUT-1:0][ACC_W-1:0]       scores,
  output logic [$clog2(N_OUT)-1:0]                 class_idx
);

  localparam int               c_KW     = $clog2(N_OUT);
  localparam logic [c_KW-1:0]  c_KLAST  = c_KW'(N_OUT - 1);
  localparam logic [5:0]       c_IDXLAST = 6'd49;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_MAC    = 2'd1;
  localparam logic [1:0] c_ARGMAX = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]                   r_state;
  logic [5:0]                   r_idx;
  logic [c_KW-1:0]              r_k;
  logic signed [ACC_W-1:0]      r_best;
  logic signed [ACC_W-1:0]      r_acc [N_OUT];
  logic signed [bitwidth-1:0]   r_x [50];
  logic signed [2*bitwidth-1:0] w_prod [N_OUT];

  assign in_ready  = (r_state == c_IDLE) && !rst;
  assign out_valid = (r_state == c_DONE);

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      w_prod[k] = $signed(weights[k][r_idx]) * r_x[r_idx];
      scores[k] = r_acc[k];
    end
  end

  // Map storage carries no reset: it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            r_x[c*25 + i*5 + j] <= featuremap_maxpooled[c][i][j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_idx     <= '0;
      r_k       <= '0;
      r_best    <= '0;
      class_idx <= '0;
      for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_OUT; k++)
              r_acc[k] <= {{(ACC_W-bitwidth){bias[k][bitwidth-1]}}, bias[k]};
            r_idx   <= '0;
            r_state <= c_MAC;
          end
        end
        c_MAC: begin
          for (int k = 0; k < N_OUT; k++)
            r_acc[k] <= r_acc[k] +
                        {{(ACC_W-2*bitwidth){w_prod[k][2*bitwidth-1]}}, w_prod[k]};
          r_idx <= r_idx + 6'd1;
          if (r_idx == c_IDXLAST) begin
            r_k     <= '0;
            r_state <= c_ARGMAX;
          end
        end
        c_ARGMAX: begin
          // Strict compare keeps the lower index on ties.
          if ((r_k == '0) || (r_acc[r_k] > r_best)) begin
            r_best    <= r_acc[r_k];
            class_idx <= r_k;
          end
          if (r_k == c_KLAST) r_state <= c_DONE;
          else                r_k     <= r_k + 1'b1;
        end
        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_classifier_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_classifier_seq
// Brief    : Scoreboard bench for fc_classifier_seq with a dot-product model.
// Revision : 1.0
// ============================================================================
module tb_fc_classifier_seq;

  localparam int BW = 8;
  localparam int N  = 10;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [1:0][4:0][4:0][BW-1:0] fmap;
  logic signed [N-1:0][49:0][BW-1:0]   wts;
  logic signed [N-1:0][BW-1:0]         bsp;
  logic signed [N-1:0][AW-1:0]         scores;
  logic [3:0]                          class_idx;

  always #5 clk = ~clk;

  fc_classifier_seq #(.bitwidth(BW), .N_OUT(N), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .featuremap_maxpooled(fmap), .weights(wts), .bias(bsp),
    .out_valid(out_valid), .out_ready(out_ready),
    .scores(scores), .class_idx(class_idx)
  );

  typedef struct packed {
    logic [N-1:0][AW-1:0] sc;
    logic [3:0]           idx;
    int                   cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   prev_valid = 0;
  bit   prev_hs = 0;
  int   ntests = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   fm[50];
  int   wt[N][50];
  int   bs[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int r8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Golden model: bias + dot product, wrapped to AW bits, then first maximum.
  function automatic exp_t model();
    exp_t   e;
    longint s, best;
    longint sv[N];
    for (int k = 0; k < N; k++) begin
      s = bs[k];
      for (int n = 0; n < 50; n++) s += longint'(wt[k][n]) * longint'(fm[n]);
      s = s & ((longint'(1) << AW) - 1);
      if (s >= (longint'(1) << (AW-1))) s -= (longint'(1) << AW);
      sv[k] = s;
      e.sc[k] = AW'(s);
    end
    e.idx = 0;
    best  = sv[0];
    for (int k = 1; k < N; k++)
      if (sv[k] > best) begin
        best  = sv[k];
        e.idx = 4'(k);
      end
    e.cyc = 0;
    return e;
  endfunction

  task automatic drive();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          fmap[c][i][j] = BW'(fm[c*25 + i*5 + j]);
    for (int k = 0; k < N; k++) begin
      bsp[k] = BW'(bs[k]);
      for (int n = 0; n < 50; n++) wts[k][n] = BW'(wt[k][n]);
    end
  endtask

  task automatic randomize_all();
    for (int n = 0; n < 50; n++) fm[n] = r8();
    for (int k = 0; k < N; k++) begin
      bs[k] = r8();
      for (int n = 0; n < 50; n++) wt[k][n] = r8();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(output int acyc);
    int   b;
    exp_t e;
    b = 0;
    acyc = -1;
    in_valid = 1'b1;
    while (!in_ready && b < 300) begin
      tick();
      b++;
    end
    if (!in_ready) chk("accept_timeout", b, 0);
    else begin
      e = model();
      tick();
      e.cyc = cyc;
      acyc  = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((q.size() != 0 || out_valid) && b < 400) begin
      tick();
      b++;
    end
    if (b >= 400) chk("done_timeout", b, 0);
  endtask

  // Monitor: pops on the first valid cycle, then checks outputs stay put.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      prev_hs    = 0;
    end else begin
      if (prev_hs) chk("valid_one_cycle", out_valid, 0);
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (!prev_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", q.size(), 1);
            have_cur = 0;
          end else begin
            cur      = q.pop_front();
            have_cur = 1;
            chk("latency", cyc - cur.cyc, 60);
          end
        end
        if (have_cur) begin
          for (int k = 0; k < N; k++)
            chk($sformatf("score%0d", k), $signed(scores[k]), $signed(cur.sc[k]));
          chk("class_idx", class_idx, cur.idx);
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, hs, b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) fm[n] = 0;
    for (int k = 0; k < N; k++) begin
      bs[k] = 0;
      for (int n = 0; n < 50; n++) wt[k][n] = 0;
    end
    drive();
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    for (int k = 0; k < N; k++) chk("rst_score", $signed(scores[k]), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Bias only
    randomize_all();
    for (int n = 0; n < 50; n++) fm[n] = 0;
    for (int k = 0; k < N; k++) bs[k] = k - 5;
    drive();
    accept(a0);
    in_valid = 1'b0;
    wait_done();

    // Single activation at [1][4][4]
    randomize_all();
    for (int n = 0; n < 50; n++) fm[n] = 0;
    fm[49] = 3;
    for (int k = 0; k < N; k++) begin
      wt[k][49] = k;
      bs[k] = 0;
    end
    drive();
    accept(a0);
    in_valid = 1'b0;
    wait_done();

    // Extremes: equal scores tie to index 0
    for (int n = 0; n < 50; n++) fm[n] = -128;
    for (int k = 0; k < N; k++) begin
      bs[k] = 127;
      for (int n = 0; n < 50; n++) wt[k][n] = -128;
    end
    drive();
    accept(a0);
    in_valid = 1'b0;
    wait_done();
    for (int n = 0; n < 50; n++) fm[n] = 127;
    for (int k = 0; k < N; k++) bs[k] = 0;
    drive();
    accept(a0);
    in_valid = 1'b0;
    wait_done();

    // Random maps
    for (int t = 0; t < 4; t++) begin
      randomize_all();
      drive();
      accept(a0);
      in_valid = 1'b0;
      wait_done();
    end

    // Backpressure with an ignored in_valid pulse
    randomize_all();
    drive();
    out_ready = 1'b0;
    accept(a0);
    in_valid = 1'b0;
    b = 0;
    while (!out_valid && b < 200) begin
      tick();
      b++;
    end
    if (!out_valid) chk("bp_valid_timeout", b, 0);
    for (int t = 0; t < 20; t++) begin
      if (t == 5) begin
        for (int n = 0; n < 50; n++) fm[n] = r8();
        drive();
        in_valid = 1'b1;
      end
      if (t == 6) in_valid = 1'b0;
      tick();
    end
    for (int n = 0; n < 50; n++) fm[n] = r8();
    drive();
    out_ready = 1'b1;
    hs = cyc + 1;
    accept(a1);
    in_valid = 1'b0;
    chk("accept_after_handshake", a1, hs + 1);
    wait_done();

    // Reset mid-MAC
    randomize_all();
    drive();
    accept(a0);
    in_valid = 1'b0;
    repeat (24) tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_class_idx", class_idx, 0);
    for (int k = 0; k < N; k++) chk("midrst_score", $signed(scores[k]), 0);
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("in_ready_after_midrst", in_ready, 1);
    randomize_all();
    drive();
    accept(a0);
    in_valid = 1'b0;
    wait_done();

    // Back-to-back
    randomize_all();
    drive();
    out_ready = 1'b1;
    accept(a0);
    for (int n = 0; n < 50; n++) fm[n] = r8();
    drive();
    accept(a1);
    in_valid = 1'b0;
    chk("back_to_back_ii", a1 - a0, 62);
    wait_done();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_classifier_seq.md
# fc_classifier_seq

Sequential fully-connected classifier stage that consumes the 2×5×5 max-pooled feature map produced by the second pooling stage. It computes `N_OUT` class scores as bias plus a dot product of the 50 flattened activations with a per-class weight row, then selects the arg-max class. It uses `N_OUT` parallel multiply-accumulate units, one activation per cycle, and valid/ready handshakes on both the input and output sides.

## Interface
Parameters:
- `bitwidth`, 8, width of activations, weights and biases (all signed two's complement).
- `N_OUT`, 10, number of output classes.
- `ACC_W`, 24, accumulator and score width (signed).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  a feature map is present on `featuremap_maxpooled`.
- `in_ready`  out  1  block can accept a map.
- `featuremap_maxpooled`  in  signed [bitwidth-1:0] [1:0][4:0][4:0]  pooled activations.
- `weights`  in  signed [bitwidth-1:0] [N_OUT-1:0][49:0]  weight rows; must be held stable from acceptance until `out_valid`.
- `bias`  in  signed [bitwidth-1:0] [N_OUT-1:0]  per-class bias; same stability rule as `weights`.
- `out_valid`  out  1  `scores` and `class_idx` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `scores`  out  signed [ACC_W-1:0] [N_OUT-1:0]  final class scores.
- `class_idx`  out  [$clog2(N_OUT)-1:0]  index of the maximum score.

## Operation
- **States:** `IDLE`, `MAC`, `ARGMAX`, `DONE`.
- **IDLE:**
  - `in_ready` = 1 (forced to 0 while `rst` is high).
  - On `in_valid & in_ready`, capture the whole feature map into an internal register.
  - Load `acc[k]` = `bias[k]`, sign-extended to `ACC_W`.
  - Set `idx` = 0 and go to `MAC`.
- **MAC:**
  - Flatten order is `idx = c*25 + i*5 + j`, for channel `c`, row `i`, column `j`.
  - Each cycle, every `acc[k] += weights[k][idx] * x[idx]`. The product is a full 2·`bitwidth` signed value, sign-extended to `ACC_W`.
  - The sum wraps two's complement at `ACC_W`; there is no saturation.
  - `idx` increments each cycle. When the update at `idx` = 49 completes, go to `ARGMAX` with `k` = 0.
- **ARGMAX:**
  - Each cycle, if `k == 0` or `acc[k] > best` (signed, strict), then `best` ← `acc[k]` and `class_idx` ← `k`.
  - Ties keep the lower index.
  - After `k` = `N_OUT-1`, go to `DONE`.
- **DONE:**
  - `out_valid` = 1, and `scores` and `class_idx` are held.
  - On `out_ready`, go to `IDLE`.
  - While `out_ready` is low, hold indefinitely with outputs stable.
- `scores` drives the accumulators directly, so its value is meaningful only while `out_valid` = 1.
- `in_valid` is ignored outside `IDLE`. The input map may change freely after acceptance.
- **Reset (asserted any time, including mid-`MAC`/`ARGMAX`):**
  - State goes to `IDLE`; `idx`, `k` and `best` clear.
  - All `acc` and `scores` go to 0; `class_idx` = 0; `out_valid` = 0.
  - The in-flight map is discarded with no partial output.
  - `in_ready` goes high on the first cycle after `rst` deasserts.

## Timing
- Acceptance edge is E0.
- MAC updates occur on E1…E50.
- ARGMAX steps occur on E51…E(50+`N_OUT`).
- `out_valid` rises after E(50+`N_OUT`). With defaults this is after E60, giving latency 60 cycles.
- Output handshake on edge Ed (`out_valid & out_ready`): `out_valid` falls and `in_ready` rises after Ed.
- The earliest next acceptance is Ed+1, so the minimum initiation interval is `N_OUT`+52 cycles (62 with defaults).
- `in_ready` and `out_valid` are never high in the same cycle.

## Test plan
- **Bias only:** all-zero map; `bias[k]` = k−5; `out_ready`=1.
  - `scores` = −5…4; `class_idx` = 9.
  - `out_valid` high exactly one cycle, 60 cycles after acceptance.
- **Single activation:** map all 0 except `[1][4][4]` = 3 (idx 49); `weights[k][49]` = k; bias 0.
  - `scores[k]` = 3k; `class_idx` = 9.
  - Confirms flatten order.
- **Extremes:** all x = −128, all w = −128, bias = 127.
  - Every score = 819327; tie resolves to `class_idx` = 0.
  - Mixed-sign case: x = 127, w = −128 gives −812800 per class; verify signed compare.
- **Backpressure:** `out_ready` low for 20 cycles after `out_valid`.
  - Outputs stable, `in_ready` = 0, and a pulsed `in_valid` is ignored.
  - On `out_ready`, the next map is accepted one cycle later.
- **Reset mid-MAC:** assert `rst` at E25 for 2 cycles.
  - All outputs go to 0 immediately (asynchronous) and no `out_valid` appears.
  - A new map after release produces correct results.
- **Back-to-back:** two different maps, `in_valid` and `out_ready` held high.
  - Second acceptance occurs 62 cycles after the first.
  - Both result sets match a golden model.
